// File: rtl/bram_axi_lite_ctrl_if.sv
// AXI4-Lite slave bus plus the narrow BRAM port driven by bram_axi_lite_ctrl.
// The slave modport is the controller's view; master is the initiator/BRAM side.
interface bram_axi_lite_ctrl_if #(
  parameter int ADDR_BITW = 32,
  parameter int DATA_BITW = 32
);
  logic [ADDR_BITW-1:0]   AwAddr_DI;
  logic                   AwValid_SI;
  logic                   AwReady_SO;
  logic [DATA_BITW-1:0]   WData_DI;
  logic [DATA_BITW/8-1:0] WStrb_DI;
  logic                   WValid_SI;
  logic                   WReady_SO;
  logic [1:0]             BResp_DO;
  logic                   BValid_SO;
  logic                   BReady_SI;
  logic [ADDR_BITW-1:0]   ArAddr_DI;
  logic                   ArValid_SI;
  logic                   ArReady_SO;
  logic [DATA_BITW-1:0]   RData_DO;
  logic [1:0]             RResp_DO;
  logic                   RValid_SO;
  logic                   RReady_SI;
  logic                   Bram_En_SO;
  logic [ADDR_BITW-1:0]   Bram_Addr_SO;
  logic [DATA_BITW/8-1:0] Bram_WrEn_SO;
  logic [DATA_BITW-1:0]   Bram_Wr_DO;
  logic [DATA_BITW-1:0]   Bram_Rd_DI;

  modport slave (
    input  AwAddr_DI, AwValid_SI, WData_DI, WStrb_DI, WValid_SI, BReady_SI,
           ArAddr_DI, ArValid_SI, RReady_SI, Bram_Rd_DI,
    output AwReady_SO, WReady_SO, BResp_DO, BValid_SO, ArReady_SO,
           RData_DO, RResp_DO, RValid_SO,
           Bram_En_SO, Bram_Addr_SO, Bram_WrEn_SO, Bram_Wr_DO
  );

  modport master (
    output AwAddr_DI, AwValid_SI, WData_DI, WStrb_DI, WValid_SI, BReady_SI,
           ArAddr_DI, ArValid_SI, RReady_SI, Bram_Rd_DI,
    input  AwReady_SO, WReady_SO, BResp_DO, BValid_SO, ArReady_SO,
           RData_DO, RResp_DO, RValid_SO,
           Bram_En_SO, Bram_Addr_SO, Bram_WrEn_SO, Bram_Wr_DO
  );
endinterface

// File: rtl/bram_axi_lite_ctrl.sv
// Single-outstanding AXI4-Lite slave mapping 32-bit register accesses onto a BRAM port,
// with round-robin arbitration between complete write requests and reads.
module bram_axi_lite_ctrl #(
  parameter int ADDR_BITW  = 32,
  parameter int DATA_BITW  = 32,
  parameter int MEM_BYTES  = 4096,
  parameter int RD_LATENCY = 1
) (
  input  logic Clk_CI,
  input  logic Rst_RI,
  output logic Bram_Clk_CO,
  output logic Bram_Rst_RO,
  bram_axi_lite_ctrl_if.slave bus
);
  localparam int STRB_W = DATA_BITW / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [ADDR_BITW:0] MEM_LIM = (ADDR_BITW+1)'(MEM_BYTES);
  localparam logic [1:0] WAIT_CNT = 2'(RD_LATENCY - 1);

  typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RWAIT, RRESP} state_e;

  state_e                 state_q;
  logic                   last_wr_q;
  logic                   in_range_q;
  logic [1:0]             cnt_q;
  logic                   bram_en_q;
  logic [STRB_W-1:0]      bram_wren_q;
  logic [ADDR_BITW-1:0]   bram_addr_q;
  logic [DATA_BITW-1:0]   bram_wr_q;
  logic [1:0]             bresp_q;
  logic [1:0]             rresp_q;
  logic [DATA_BITW-1:0]   rdata_q;

  logic wr_pend, rd_pend, idle_ok, wr_sel, rd_sel, cap_now;
  logic [DATA_BITW-1:0] rd_cap;
  logic [1:0]           rresp_now;

  function automatic logic addr_ok(input logic [ADDR_BITW-1:0] a);
    return {1'b0, a} < MEM_LIM;
  endfunction

  function automatic logic [ADDR_BITW-1:0] word_addr(input logic [ADDR_BITW-1:0] a);
    return {a[ADDR_BITW-1:2], 2'b00};
  endfunction

  // Readies are held low during reset so nothing is accepted while Rst_RI is high.
  always_comb begin
    wr_pend = bus.AwValid_SI & bus.WValid_SI;
    rd_pend = bus.ArValid_SI;
    idle_ok = (state_q == IDLE) & ~Rst_RI;
    rd_sel  = idle_ok & rd_pend & (~wr_pend | last_wr_q);
    wr_sel  = idle_ok & wr_pend & (~rd_pend | ~last_wr_q);
  end

  // In the final RWAIT cycle the response is presented straight from the BRAM
  // output while it is captured, so RValid rises in the capture cycle itself.
  always_comb begin
    cap_now   = (state_q == RWAIT) && (cnt_q == 2'd0);
    rd_cap    = in_range_q ? bus.Bram_Rd_DI : '0;
    rresp_now = in_range_q ? RESP_OKAY : RESP_SLVERR;
  end

  always_ff @(posedge Clk_CI or posedge Rst_RI) begin
    if (Rst_RI) begin
      state_q     <= IDLE;
      last_wr_q   <= 1'b1;
      in_range_q  <= 1'b0;
      cnt_q       <= 2'd0;
      bram_en_q   <= 1'b0;
      bram_wren_q <= '0;
      bram_addr_q <= '0;
      bram_wr_q   <= '0;
      bresp_q     <= RESP_OKAY;
      rresp_q     <= RESP_OKAY;
      rdata_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (rd_sel) begin
            state_q     <= RD;
            last_wr_q   <= 1'b0;
            in_range_q  <= addr_ok(bus.ArAddr_DI);
            bram_en_q   <= addr_ok(bus.ArAddr_DI);
            bram_wren_q <= '0;
            bram_addr_q <= word_addr(bus.ArAddr_DI);
          end else if (wr_sel) begin
            state_q     <= WR;
            last_wr_q   <= 1'b1;
            in_range_q  <= addr_ok(bus.AwAddr_DI);
            bram_en_q   <= addr_ok(bus.AwAddr_DI);
            bram_wren_q <= addr_ok(bus.AwAddr_DI) ? bus.WStrb_DI : '0;
            bram_addr_q <= word_addr(bus.AwAddr_DI);
            bram_wr_q   <= bus.WData_DI;
          end
        end
        WR: begin
          bram_en_q   <= 1'b0;
          bram_wren_q <= '0;
          bresp_q     <= in_range_q ? RESP_OKAY : RESP_SLVERR;
          state_q     <= WRESP;
        end
        WRESP: begin
          if (bus.BReady_SI) state_q <= IDLE;
        end
        RD: begin
          bram_en_q <= 1'b0;
          cnt_q     <= WAIT_CNT;
          state_q   <= RWAIT;
        end
        RWAIT: begin
          if (cnt_q != 2'd0) begin
            cnt_q <= cnt_q - 2'd1;
          end else begin
            rdata_q <= rd_cap;
            rresp_q <= rresp_now;
            state_q <= bus.RReady_SI ? IDLE : RRESP;
          end
        end
        RRESP: begin
          if (bus.RReady_SI) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Bram_Clk_CO      = Clk_CI;
  assign Bram_Rst_RO      = Rst_RI;
  assign bus.AwReady_SO   = wr_sel;
  assign bus.WReady_SO    = wr_sel;
  assign bus.ArReady_SO   = rd_sel;
  assign bus.BValid_SO    = (state_q == WRESP);
  assign bus.BResp_DO     = bresp_q;
  assign bus.RValid_SO    = cap_now | (state_q == RRESP);
  assign bus.RData_DO     = cap_now ? rd_cap : rdata_q;
  assign bus.RResp_DO     = cap_now ? rresp_now : rresp_q;
  assign bus.Bram_En_SO   = bram_en_q;
  assign bus.Bram_WrEn_SO = bram_wren_q;
  assign bus.Bram_Addr_SO = bram_addr_q;
  assign bus.Bram_Wr_DO   = bram_wr_q;
endmodule

// File: tb/tb_bram_axi_lite_ctrl.sv
// Scoreboard bench: a latency-1 instance under randomized traffic against a word-array
// reference memory, plus a latency-2 instance for read timing and reset mid-read.
module tb_bram_axi_lite_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1, rst2;
  logic bclk1, brst1, bclk2, brst2;

  bram_axi_lite_ctrl_if #(.ADDR_BITW(32), .DATA_BITW(32)) if1 ();
  bram_axi_lite_ctrl_if #(.ADDR_BITW(32), .DATA_BITW(32)) if2 ();

  bram_axi_lite_ctrl #(.ADDR_BITW(32), .DATA_BITW(32), .MEM_BYTES(4096), .RD_LATENCY(1)) u_dut1 (
    .Clk_CI(clk), .Rst_RI(rst1), .Bram_Clk_CO(bclk1), .Bram_Rst_RO(brst1), .bus(if1.slave));
  bram_axi_lite_ctrl #(.ADDR_BITW(32), .DATA_BITW(32), .MEM_BYTES(4096), .RD_LATENCY(2)) u_dut2 (
    .Clk_CI(clk), .Rst_RI(rst2), .Bram_Clk_CO(bclk2), .Bram_Rst_RO(brst2), .bus(if2.slave));

  // BRAM models: latency 1 for instance 1, latency 2 for instance 2
  logic [31:0] mem1 [0:1023] = '{default: '0};
  logic [31:0] mem2 [0:1023] = '{default: '0};
  logic [31:0] rd1_q = '0, rd2a_q = '0, rd2b_q = '0;

  always @(posedge clk) begin
    if (if1.Bram_En_SO) begin
      for (int b = 0; b < 4; b++)
        if (if1.Bram_WrEn_SO[b]) mem1[if1.Bram_Addr_SO[11:2]][8*b +: 8] <= if1.Bram_Wr_DO[8*b +: 8];
      rd1_q <= mem1[if1.Bram_Addr_SO[11:2]];
    end
    if (if2.Bram_En_SO) begin
      for (int b = 0; b < 4; b++)
        if (if2.Bram_WrEn_SO[b]) mem2[if2.Bram_Addr_SO[11:2]][8*b +: 8] <= if2.Bram_Wr_DO[8*b +: 8];
      rd2a_q <= mem2[if2.Bram_Addr_SO[11:2]];
    end
    rd2b_q <= rd2a_q;
  end
  assign if1.Bram_Rd_DI = rd1_q;
  assign if2.Bram_Rd_DI = rd2b_q;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
  endtask

  // Reference model: byte-addressed window of 4096 bytes, word storage, OKAY/SLVERR
  typedef struct { bit is_rd; logic [31:0] data; logic [1:0] resp; } exp_t;
  exp_t exp_q[$];
  logic [31:0] ref_mem [int];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    int idx;
    idx = int'(a >> 2);
    return ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
  endfunction

  task automatic ref_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = ref_rd(a);
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    ref_mem[int'(a >> 2)] = v;
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.is_rd = 1'b0; e.data = '0;
    e.resp = (a < 32'd4096) ? 2'b00 : 2'b10;
    if (a < 32'd4096) ref_wr(a, d, s);
    exp_q.push_back(e);
  endtask

  task automatic push_rd(input logic [31:0] a);
    exp_t e;
    e.is_rd = 1'b1;
    e.data = (a < 32'd4096) ? ref_rd(a) : 32'h0;
    e.resp = (a < 32'd4096) ? 2'b00 : 2'b10;
    exp_q.push_back(e);
  endtask

  // Response monitor for instance 1
  always @(negedge clk) begin
    exp_t e;
    if (!rst1 && if1.BValid_SO && if1.BReady_SI) begin
      chk("b_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("b_order_kind", e.is_rd, 0);
        chk("bresp", if1.BResp_DO, e.resp);
      end
    end
    if (!rst1 && if1.RValid_SO && if1.RReady_SI) begin
      chk("r_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("r_order_kind", e.is_rd, 1);
        chk("rdata", if1.RData_DO, e.data);
        chk("rresp", if1.RResp_DO, e.resp);
      end
    end
  end

  int en1_cnt = 0;
  always @(negedge clk) if (if1.Bram_En_SO) en1_cnt++;

  bit rready_low = 1'b0;
  initial begin
    if1.BReady_SI = 1'b0;
    if1.RReady_SI = 1'b0;
    forever begin
      @(posedge clk); #1;
      if1.BReady_SI = ($urandom_range(0, 3) != 0);
      if1.RReady_SI = rready_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic drain();
    for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(negedge clk);
    chk("drain_outstanding", exp_q.size(), 0);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int waits);
    bit got;
    bit inr;
    inr = (a < 32'd4096);
    @(posedge clk); #1;
    if1.AwAddr_DI = a; if1.WData_DI = d; if1.WStrb_DI = s;
    if1.AwValid_SI = 1'b1; if1.WValid_SI = 1'b1;
    push_wr(a, d, s);
    waits = 0; got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (if1.AwReady_SO || if1.WReady_SO) got = 1'b1;
      else waits++;
    end
    chk("wr_accept", got, 1);
    chk("wr_readies_together", {if1.AwReady_SO, if1.WReady_SO}, 2'b11);
    @(posedge clk); #1;
    if1.AwValid_SI = 1'b0; if1.WValid_SI = 1'b0;
    @(negedge clk);
    chk("wr_bram_en", if1.Bram_En_SO, inr);
    chk("wr_bram_wren", if1.Bram_WrEn_SO, inr ? s : 4'h0);
    if (inr) begin
      chk("wr_bram_addr", if1.Bram_Addr_SO, a & 32'hFFFF_FFFC);
      chk("wr_bram_data", if1.Bram_Wr_DO, d);
    end
    chk("wr_bvalid_early", if1.BValid_SO, 0);
    @(negedge clk);
    chk("wr_bvalid_t2", if1.BValid_SO, 1);
  endtask

  task automatic do_read(input logic [31:0] a, output int waits);
    bit got;
    bit inr;
    inr = (a < 32'd4096);
    @(posedge clk); #1;
    if1.ArAddr_DI = a; if1.ArValid_SI = 1'b1;
    push_rd(a);
    waits = 0; got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      if (if1.ArReady_SO) got = 1'b1;
      else waits++;
    end
    chk("rd_accept", got, 1);
    @(posedge clk); #1;
    if1.ArValid_SI = 1'b0;
    @(negedge clk);
    chk("rd_bram_en", if1.Bram_En_SO, inr);
    chk("rd_bram_wren", if1.Bram_WrEn_SO, 0);
    if (inr) chk("rd_bram_addr", if1.Bram_Addr_SO, a & 32'hFFFF_FFFC);
    chk("rd_rvalid_early", if1.RValid_SO, 0);
    @(negedge clk);
    chk("rd_rvalid_t2", if1.RValid_SO, 1);
  endtask

  initial begin
    int w, n, cyc, c0, bad;
    bit last_wr, stable;
    logic [31:0] cap_d, a, d;
    logic [1:0] cap_r;

    rst1 = 1'b1; rst2 = 1'b1;
    // Instance 1: write and read requests held from reset
    if1.AwAddr_DI = 32'h20; if1.WData_DI = 32'hA5A5_A5A5; if1.WStrb_DI = 4'hF;
    if1.ArAddr_DI = 32'h20; if1.AwValid_SI = 1'b1; if1.WValid_SI = 1'b1; if1.ArValid_SI = 1'b1;
    if2.AwAddr_DI = '0; if2.WData_DI = '0; if2.WStrb_DI = '0; if2.ArAddr_DI = '0;
    if2.AwValid_SI = 1'b0; if2.WValid_SI = 1'b0; if2.ArValid_SI = 1'b0;
    if2.BReady_SI = 1'b1; if2.RReady_SI = 1'b1;
    repeat (3) @(negedge clk);

    chk("rst_awready", if1.AwReady_SO, 0);
    chk("rst_wready", if1.WReady_SO, 0);
    chk("rst_arready", if1.ArReady_SO, 0);
    chk("rst_bvalid", if1.BValid_SO, 0);
    chk("rst_rvalid", if1.RValid_SO, 0);
    chk("rst_bram_en", if1.Bram_En_SO, 0);
    chk("rst_bram_wren", if1.Bram_WrEn_SO, 0);
    chk("rst_bram_addr", if1.Bram_Addr_SO, 0);
    chk("rst_bram_wr", if1.Bram_Wr_DO, 0);
    chk("rst_rdata", if1.RData_DO, 0);
    chk("rst_bresp", if1.BResp_DO, 0);
    chk("rst_rresp", if1.RResp_DO, 0);
    chk("rst_bram_rst_copy", brst1, 1);
    chk("lat2_rst_rvalid", if2.RValid_SO, 0);

    // Round robin starts with the read after reset, then alternates
    last_wr = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (last_wr) begin push_rd(32'h20); last_wr = 1'b0; end
      else begin push_wr(32'h20, 32'hA5A5_A5A5, 4'hF); last_wr = 1'b1; end
    end
    rst1 = 1'b0; #1;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 80) begin
      if (if1.ArReady_SO || if1.AwReady_SO) n++;
      if (n < 4) begin @(negedge clk); cyc++; end
    end
    chk("simul_accepts", n, 4);
    @(posedge clk); #1;
    if1.AwValid_SI = 1'b0; if1.WValid_SI = 1'b0; if1.ArValid_SI = 1'b0;
    drain();
    chk("bram_rst_copy_low", brst1, 0);
    chk("bram_clk_copy", bclk1, clk);

    // Basic write/read, partial strobe with unaligned address
    do_write(32'h10, 32'hDEAD_BEEF, 4'hF, w);
    do_read(32'h10, w);
    do_write(32'h13, 32'h1122_3344, 4'h2, w);
    do_read(32'h10, w);
    drain();

    // Out of range: no BRAM enable, SLVERR, zero data
    c0 = en1_cnt;
    do_read(32'h1000, w);
    do_write(32'h2000, 32'hCAFE_F00D, 4'hF, w);
    drain();
    chk("oor_no_bram_en", en1_cnt, c0);

    // Read backpressure: response frozen for 10 cycles
    rready_low = 1'b1;
    do_read(32'h10, w);
    cap_d = if1.RData_DO; cap_r = if1.RResp_DO;
    stable = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (if1.RValid_SO !== 1'b1 || if1.RData_DO !== cap_d || if1.RResp_DO !== cap_r ||
          if1.Bram_En_SO !== 1'b0 || if1.ArReady_SO !== 1'b0 || if1.AwReady_SO !== 1'b0)
        stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    rready_low = 1'b0;
    drain();

    // W three cycles before AW: no readies until AW joins
    @(posedge clk); #1;
    if1.WData_DI = 32'h0BAD_F00D; if1.WStrb_DI = 4'hC; if1.WValid_SI = 1'b1;
    stable = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (if1.WReady_SO !== 1'b0 || if1.AwReady_SO !== 1'b0) stable = 1'b0;
    end
    chk("w_alone_no_ready", stable, 1);
    do_write(32'h24, 32'h0BAD_F00D, 4'hC, w);
    chk("w_aw_join_wait", w, 0);
    drain();

    // Randomized traffic, some of it outside the window
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 32'h13FF));
      d = $urandom;
      if ($urandom_range(0, 1) == 1) do_write(a, d, 4'($urandom_range(0, 15)), w);
      else do_read(a, w);
    end
    drain();

    // Instance 2, read latency 2
    @(negedge clk); rst2 = 1'b0;
    @(posedge clk); #1;
    if2.AwAddr_DI = 32'h40; if2.WData_DI = 32'h55AA_1234; if2.WStrb_DI = 4'hF;
    if2.AwValid_SI = 1'b1; if2.WValid_SI = 1'b1;
    @(negedge clk); chk("lat2_wr_accept", if2.AwReady_SO & if2.WReady_SO, 1);
    @(posedge clk); #1; if2.AwValid_SI = 1'b0; if2.WValid_SI = 1'b0;
    @(negedge clk); chk("lat2_wr_en", {if2.Bram_En_SO, if2.Bram_WrEn_SO}, 5'h1F);
    @(negedge clk); chk("lat2_bvalid", {if2.BValid_SO, if2.BResp_DO}, 3'b100);
    @(posedge clk); #1;
    if2.ArAddr_DI = 32'h40; if2.ArValid_SI = 1'b1;
    @(negedge clk); chk("lat2_rd_accept", if2.ArReady_SO, 1);
    @(posedge clk); #1; if2.ArValid_SI = 1'b0;
    @(negedge clk); chk("lat2_rd_en", if2.Bram_En_SO, 1); chk("lat2_rvalid_t1", if2.RValid_SO, 0);
    @(negedge clk); chk("lat2_rvalid_t2", if2.RValid_SO, 0);
    @(negedge clk); chk("lat2_rvalid_t3", if2.RValid_SO, 1);
    chk("lat2_rdata", if2.RData_DO, 32'h55AA_1234);
    chk("lat2_rresp", if2.RResp_DO, 0);
    @(posedge clk); #1;
    if2.ArAddr_DI = 32'h40; if2.ArValid_SI = 1'b1;
    @(negedge clk); chk("lat2_rd2_accept", if2.ArReady_SO, 1);
    @(posedge clk); #1; if2.ArValid_SI = 1'b0;
    // Reset lands in the first RWAIT cycle
    @(posedge clk); #1; rst2 = 1'b1; #1;
    chk("midrst_rvalid", if2.RValid_SO, 0);
    chk("midrst_bram_en", if2.Bram_En_SO, 0);
    chk("midrst_bram_addr", if2.Bram_Addr_SO, 0);
    chk("midrst_bram_wr", if2.Bram_Wr_DO, 0);
    chk("midrst_rdata", if2.RData_DO, 0);
    chk("midrst_readies", {if2.ArReady_SO, if2.AwReady_SO, if2.WReady_SO}, 0);
    chk("midrst_bram_rst", brst2, 1);
    @(posedge clk); #1; rst2 = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (if2.RValid_SO !== 1'b0 || if2.Bram_En_SO !== 1'b0) bad++;
    end
    chk("midrst_no_r_beat", bad, 0);
    chk("lat2_bram_clk_copy", bclk2, clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
